// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU control stage: ALU operation codes,
// main-control ALUOp classes and queue sizing.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_PASS = 4'b0011,
    ALU_XOR  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_EQ   = 4'b1000,
    ALU_NE   = 4'b1001,
    ALU_GE   = 4'b1010,
    ALU_LUI  = 4'b1011,
    ALU_LT   = 4'b1100,
    ALU_SRA  = 4'b1110,
    ALU_SRL  = 4'b1111
  } alu_op_t;

  typedef enum logic [2:0] {
    LDST  = 3'b000,
    BR    = 3'b001,
    RTYPE = 3'b010,
    ITYPE = 3'b011,
    LUI   = 3'b100,
    JUMP  = 3'b101
  } aluop_class_t;

  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam int         QUEUE_DEPTH = 2;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of ALUOp class + Funct3/Funct7 into an ALU operation
// code and an illegal flag. Illegal encodings always decode to ADD.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] aluop,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_t    op,
  output logic       illegal
);

  logic    f7_ok;
  logic    is_r;
  alu_op_t raw_op;

  assign f7_ok = (funct7 == 7'b0000000) || (funct7 == FUNCT7_ALT);
  assign is_r  = (aluop == RTYPE);

  always_comb begin
    raw_op  = ALU_ADD;
    illegal = 1'b0;
    case (aluop)
      LDST: raw_op = ALU_ADD;
      BR: begin
        case (funct3)
          3'b000:  raw_op = ALU_EQ;
          3'b001:  raw_op = ALU_NE;
          3'b100:  raw_op = ALU_LT;
          3'b101:  raw_op = ALU_GE;
          default: illegal = 1'b1;
        endcase
      end
      RTYPE, ITYPE: begin
        // I-type ignores Funct7 except on the shifts, where it selects SRA/SRL.
        case (funct3)
          3'b000: begin
            raw_op  = (is_r && funct7[5]) ? ALU_SUB : ALU_ADD;
            illegal = is_r && !f7_ok;
          end
          3'b001: begin
            raw_op  = ALU_SLL;
            illegal = !f7_ok;
          end
          3'b101: begin
            raw_op  = funct7[5] ? ALU_SRA : ALU_SRL;
            illegal = !f7_ok;
          end
          3'b010: begin
            raw_op  = ALU_LT;
            illegal = is_r && !f7_ok;
          end
          3'b100: begin
            raw_op  = ALU_XOR;
            illegal = is_r && !f7_ok;
          end
          3'b110: begin
            raw_op  = ALU_OR;
            illegal = is_r && !f7_ok;
          end
          3'b111: begin
            raw_op  = ALU_AND;
            illegal = is_r && !f7_ok;
          end
          default: illegal = 1'b1;
        endcase
      end
      LUI:     raw_op = ALU_LUI;
      JUMP:    raw_op = ALU_PASS;
      default: illegal = 1'b1;
    endcase
  end

  assign op = illegal ? ALU_ADD : raw_op;

endmodule

// File: rtl/alu_ctrl_stage.sv
// ALU control stage: decodes at push and buffers {operation, tag} in a 2-entry
// FIFO. Optional ALU_CTRL_ILLEGAL_EN adds out_illegal and illegal_count.
module alu_ctrl_stage
  import alu_ctrl_pkg::*;
#(
  parameter int OPCODE_LENGTH = 4,
  parameter int TAG_WIDTH     = 32,
  parameter int ALUOP_WIDTH   = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ALUOP_WIDTH-1:0]   ALUOp,
  input  logic [2:0]               Funct3,
  input  logic [6:0]               Funct7,
  input  logic [TAG_WIDTH-1:0]     in_tag,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [TAG_WIDTH-1:0]     out_tag
`ifdef ALU_CTRL_ILLEGAL_EN
  ,
  output logic                     out_illegal,
  output logic [7:0]               illegal_count
`endif
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; all outputs are registered, and flush cancels both transfers that cycle.
  alu_op_t dec_op;
  logic    dec_ill;

  alu_ctrl_decode u_decode (
    .aluop   (3'(ALUOp)),
    .funct3  (Funct3),
    .funct7  (Funct7),
    .op      (dec_op),
    .illegal (dec_ill)
  );

  logic [OPCODE_LENGTH-1:0] op_mem  [QUEUE_DEPTH];
  logic [TAG_WIDTH-1:0]     tag_mem [QUEUE_DEPTH];
  logic                     wr_ptr, rd_ptr, rd_ptr_n;
  logic [1:0]               count, count_n;
  logic                     push, pop, head_from_in;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + 2'd1;
      2'b01:   count_n = count - 2'd1;
      default: count_n = count;
    endcase
  end

  assign rd_ptr_n = rd_ptr ^ pop;
  // The new head is the incoming entry when it lands in the slot read next.
  assign head_from_in = push && (wr_ptr == rd_ptr_n);

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      Operation <= '0;
      out_tag   <= '0;
    end else if (flush) begin
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      if (push) begin
        op_mem[wr_ptr]  <= OPCODE_LENGTH'(dec_op);
        tag_mem[wr_ptr] <= in_tag;
        wr_ptr          <= ~wr_ptr;
      end
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      out_valid <= (count_n != 2'd0);
      in_ready  <= (count_n < 2'(QUEUE_DEPTH));
      if (count_n != 2'd0) begin
        Operation <= head_from_in ? OPCODE_LENGTH'(dec_op) : op_mem[rd_ptr_n];
        out_tag   <= head_from_in ? in_tag : tag_mem[rd_ptr_n];
      end
    end
  end

`ifdef ALU_CTRL_ILLEGAL_EN
  logic ill_mem [QUEUE_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      out_illegal   <= 1'b0;
      illegal_count <= 8'd0;
    end else if (!flush) begin
      if (push) begin
        ill_mem[wr_ptr] <= dec_ill;
        if (dec_ill && (illegal_count != 8'hFF))
          illegal_count <= illegal_count + 8'd1;
      end
      if (count_n != 2'd0)
        out_illegal <= head_from_in ? dec_ill : ill_mem[rd_ptr_n];
    end
  end
`else
  logic unused_ill;
  assign unused_ill = dec_ill;
`endif

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed self-checking bench for alu_ctrl_stage (also covers
// ALU_CTRL_ILLEGAL_EN when that macro is defined).
module tb_alu_ctrl_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ALUOp;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic [31:0] in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  Operation;
  logic [31:0] out_tag;
`ifdef ALU_CTRL_ILLEGAL_EN
  logic        out_illegal;
  logic [7:0]  illegal_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int exp_ill_count = 0;
  logic [4:0] exp_q[$];

  alu_ctrl_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUOp     (ALUOp),
    .Funct3    (Funct3),
    .Funct7    (Funct7),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Operation (Operation),
    .out_tag   (out_tag)
`ifdef ALU_CTRL_ILLEGAL_EN
    ,
    .out_illegal   (out_illegal),
    .illegal_count (illegal_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic [2:0] op_cls, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] tag);
    in_valid = v;
    ALUOp    = op_cls;
    Funct3   = f3;
    Funct7   = f7;
    in_tag   = tag;
  endtask

  // Push one instruction into an empty queue, check the head, then drain it.
  task automatic vec(input string name, input logic [2:0] op_cls, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] tag,
                     input logic [3:0] exp_op, input logic exp_ill);
    logic [4:0] e;
    out_ready = 1'b1;
    drive(1'b1, op_cls, f3, f7, tag);
    exp_q.push_back({exp_ill, exp_op});
    if (exp_ill) exp_ill_count++;
    tick();
    in_valid = 1'b0;
    e = exp_q.pop_front();
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_op"}, 32'(Operation), 32'(e[3:0]));
    chk({name, "_tag"}, out_tag, tag);
`ifdef ALU_CTRL_ILLEGAL_EN
    chk({name, "_ill"}, 32'(out_illegal), 32'(e[4]));
    chk({name, "_icnt"}, 32'(illegal_count), 32'(exp_ill_count));
`endif
    tick();
    chk({name, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 3'b000, 3'b000, 7'b0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_op", 32'(Operation), 32'h0);
    chk("rst_tag", out_tag, 32'h0);
`ifdef ALU_CTRL_ILLEGAL_EN
    chk("rst_ill", 32'(out_illegal), 32'd0);
    chk("rst_icnt", 32'(illegal_count), 32'd0);
`endif

    // SUB with immediate consume
    out_ready = 1'b1;
    drive(1'b1, 3'b010, 3'b000, 7'b0100000, 32'h40);
    tick();
    in_valid = 1'b0;
    chk("sub_valid", 32'(out_valid), 32'd1);
    chk("sub_op", 32'(Operation), 32'h6);
    chk("sub_tag", out_tag, 32'h40);
    tick();
    chk("sub_empty", 32'(out_valid), 32'd0);
    chk("sub_hold_op", 32'(Operation), 32'h6);
    chk("sub_ready", 32'(in_ready), 32'd1);

    // Fill the queue with consumer stalled
    out_ready = 1'b0;
    drive(1'b1, 3'b001, 3'b101, 7'b0, 32'h1);
    tick();
    chk("fill1_ready", 32'(in_ready), 32'd1);
    chk("fill1_op", 32'(Operation), 32'hA);
    drive(1'b1, 3'b011, 3'b101, 7'b0100000, 32'h2);
    tick();
    chk("fill2_ready", 32'(in_ready), 32'd0);
    chk("fill2_op", 32'(Operation), 32'hA);
    chk("fill2_tag", out_tag, 32'h1);
    drive(1'b1, 3'b010, 3'b111, 7'b0, 32'h3);
    tick();
    chk("refused_ready", 32'(in_ready), 32'd0);
    chk("refused_tag", out_tag, 32'h1);

    // Full queue, push offered alongside a pop: only the pop happens
    out_ready = 1'b1;
    tick();
    chk("pop1_valid", 32'(out_valid), 32'd1);
    chk("pop1_op", 32'(Operation), 32'hE);
    chk("pop1_tag", out_tag, 32'h2);
    chk("pop1_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("third_acc_ready", 32'(in_ready), 32'd0);
    chk("third_acc_tag", out_tag, 32'h2);
    out_ready = 1'b1;
    tick();
    chk("pop2_op", 32'(Operation), 32'h0);
    chk("pop2_tag", out_tag, 32'h3);
    chk("pop2_ready", 32'(in_ready), 32'd1);
    tick();
    chk("pop3_valid", 32'(out_valid), 32'd0);

    // Flush with a full queue and a same-cycle input
    out_ready = 1'b0;
    drive(1'b1, 3'b100, 3'b000, 7'b0, 32'h5);
    tick();
    drive(1'b1, 3'b101, 3'b000, 7'b0, 32'h6);
    tick();
    chk("pre_flush_ready", 32'(in_ready), 32'd0);
    chk("pre_flush_op", 32'(Operation), 32'hB);
    drive(1'b1, 3'b000, 3'b000, 7'b0, 32'h7);
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    chk("flush_hold_op", 32'(Operation), 32'hB);
    chk("flush_hold_tag", out_tag, 32'h5);
    tick();
    chk("flush_idle_valid", 32'(out_valid), 32'd0);
    vec("post_flush", 3'b000, 3'b000, 7'b0, 32'h8, 4'h2, 1'b0);

    // Decode table vectors
    vec("r_illegal_f3", 3'b010, 3'b011, 7'b0, 32'h9, 4'h2, 1'b1);
    vec("r_sll", 3'b010, 3'b001, 7'b0, 32'hA, 4'h7, 1'b0);
    vec("r_slt", 3'b010, 3'b010, 7'b0, 32'hB, 4'hC, 1'b0);
    vec("r_add", 3'b010, 3'b000, 7'b0, 32'hC, 4'h2, 1'b0);
    vec("r_or", 3'b010, 3'b110, 7'b0, 32'hD, 4'h1, 1'b0);
    vec("r_srl", 3'b010, 3'b101, 7'b0, 32'hE, 4'hF, 1'b0);
    vec("r_bad_f7", 3'b010, 3'b000, 7'b0000001, 32'hF, 4'h2, 1'b1);
    vec("i_addi_alt", 3'b011, 3'b000, 7'b0100000, 32'h10, 4'h2, 1'b0);
    vec("i_xori_f7", 3'b011, 3'b100, 7'b1111111, 32'h11, 4'h5, 1'b0);
    vec("br_ne", 3'b001, 3'b001, 7'b0, 32'h12, 4'h9, 1'b0);
    vec("br_eq", 3'b001, 3'b000, 7'b0, 32'h13, 4'h8, 1'b0);
    vec("br_lt", 3'b001, 3'b100, 7'b0, 32'h14, 4'hC, 1'b0);
    vec("br_illegal", 3'b001, 3'b010, 7'b0, 32'h15, 4'h2, 1'b1);
    vec("jump_pass", 3'b101, 3'b000, 7'b0, 32'h16, 4'h3, 1'b0);
    vec("class_110", 3'b110, 3'b000, 7'b0, 32'h17, 4'h2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
